// File: rtl/mips_pkg.sv
// Shared MIPS encodings, forwarding-select constants and the hazard tracking slot record.
// Imported by the hazard/forwarding unit and its decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic [4:0] dest;
        logic       writes;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{dest: REG_ZERO, writes: 1'b0, is_load: 1'b0};

    // Youngest producer wins; a slot only ever writes with a non-zero dest, so $0 never matches.
    function automatic logic [1:0] fwd_select(input logic       used,
                                              input logic [4:0] src,
                                              input slot_t      slot_e,
                                              input slot_t      slot_m);
        logic [1:0] sel;
        sel = FWD_REG;
        if (used && slot_e.writes && (slot_e.dest == src)) begin
            sel = FWD_MEM;
        end else if (used && slot_m.writes && (slot_m.dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hfu_decode.sv
// Combinational ID-stage decode of source usage and destination register for hazard tracking.
// A destination of $0 is reported as "no write".
module hfu_decode
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_dest,
    output logic        o_writes,
    output logic        o_is_load,
    output logic        o_uses_rs,
    output logic        o_uses_rt
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rd;
    logic [4:0] w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign o_rs           = i_instr[25:21];
    assign o_rt           = i_instr[20:16];
    assign w_rd           = i_instr[15:11];
    assign w_unused_shamt = i_instr[10:6];
    assign w_funct        = i_instr[5:0];

    always_comb begin
        o_dest    = REG_ZERO;
        o_is_load = 1'b0;
        o_uses_rs = 1'b0;
        o_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_dest    = (w_funct == FN_JR) ? REG_ZERO : w_rd;
                o_uses_rs = !((w_funct == FN_SLL) || (w_funct == FN_SRL) ||
                              (w_funct == FN_SRA));
                o_uses_rt = 1'b1;
            end
            OP_JAL: begin
                o_dest = REG_RA;
            end
            OP_BEQ, OP_BNE: begin
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                o_uses_rs = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                o_dest    = o_rt;
                o_uses_rs = 1'b1;
            end
            OP_LUI: begin
                o_dest = o_rt;
            end
            OP_LB, OP_LW, OP_LBU: begin
                o_dest    = o_rt;
                o_is_load = 1'b1;
                o_uses_rs = 1'b1;
            end
            OP_SB, OP_SW: begin
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_writes = (o_dest != REG_ZERO);

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow ID/EX, EX/MEM, MEM/WB destination tracking; produces registered EX forwarding selects
// and the combinational load-use stall for the five-stage MIPS pipeline.
module hazard_forward_unit
    import mips_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] Instruction_IN,
    input  logic        Hold_IN,
    input  logic        Flush_IN,
    output logic        Stall_OUT,
    output logic [1:0]  ForwardA_OUT,
    output logic [1:0]  ForwardB_OUT
);

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_dest;
    logic       w_writes;
    logic       w_is_load;
    logic       w_uses_rs;
    logic       w_uses_rt;

    slot_t      w_id_slot;
    slot_t      w_next_e;
    slot_t      r_slot_e;
    slot_t      r_slot_m;
    slot_t      r_slot_w;
    slot_t      w_unused_slot_w;

    logic       w_load_hit;
    logic       w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_next_fwd_a;
    logic [1:0] w_next_fwd_b;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    hfu_decode u_decode (
        .i_instr   (Instruction_IN),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_dest    (w_dest),
        .o_writes  (w_writes),
        .o_is_load (w_is_load),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt)
    );

    assign w_id_slot = '{dest: w_dest, writes: w_writes, is_load: w_is_load};

    assign w_load_hit = r_slot_e.writes && r_slot_e.is_load &&
                        ((w_uses_rs && (w_rs == r_slot_e.dest)) ||
                         (w_uses_rt && (w_rt == r_slot_e.dest)));

    // A flushed ID instruction never reaches EX, so it cannot cause a load-use stall.
    assign Stall_OUT = w_load_hit && !Flush_IN;
    assign w_bubble  = Stall_OUT || Flush_IN;

    assign w_fwd_a = fwd_select(w_uses_rs, w_rs, r_slot_e, r_slot_m);
    assign w_fwd_b = fwd_select(w_uses_rt, w_rt, r_slot_e, r_slot_m);

    always_comb begin
        w_next_e     = w_id_slot;
        w_next_fwd_a = w_fwd_a;
        w_next_fwd_b = w_fwd_b;
        if (w_bubble) begin
            w_next_e     = SLOT_EMPTY;
            w_next_fwd_a = FWD_REG;
            w_next_fwd_b = FWD_REG;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_slot_e <= SLOT_EMPTY;
            r_slot_m <= SLOT_EMPTY;
            r_slot_w <= SLOT_EMPTY;
            r_fwd_a  <= FWD_REG;
            r_fwd_b  <= FWD_REG;
        end else if (!Hold_IN) begin
            r_slot_w <= r_slot_m;
            r_slot_m <= r_slot_e;
            r_slot_e <= w_next_e;
            r_fwd_a  <= w_next_fwd_a;
            r_fwd_b  <= w_next_fwd_b;
        end
    end

    // The regfile is write-first, so the MEM/WB slot is tracked but never selects a bypass.
    assign w_unused_slot_w = r_slot_w;

    assign ForwardA_OUT = r_fwd_a;
    assign ForwardB_OUT = r_fwd_b;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed plus randomized bench for hazard_forward_unit against an in-flight instruction model.
module tb_hazard_forward_unit;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Instruction_IN = 32'd0;
    logic        Hold_IN = 1'b0;
    logic        Flush_IN = 1'b0;
    logic        Stall_OUT;
    logic [1:0]  ForwardA_OUT;
    logic [1:0]  ForwardB_OUT;

    int n_total = 0;
    int n_bad   = 0;

    // Model: instruction words in EX and MEM (NOP = bubble), and the selects owed to EX.
    logic [31:0] m_ex  = 32'd0;
    logic [31:0] m_mem = 32'd0;
    logic [1:0]  m_fa  = 2'b00;
    logic [1:0]  m_fb  = 2'b00;
    logic        m_stall = 1'b0;

    hazard_forward_unit dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .Instruction_IN (Instruction_IN),
        .Hold_IN        (Hold_IN),
        .Flush_IN       (Flush_IN),
        .Stall_OUT      (Stall_OUT),
        .ForwardA_OUT   (ForwardA_OUT),
        .ForwardB_OUT   (ForwardB_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
        return w;
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
        return w;
    endfunction

    // Destination register written by an instruction; 0 means it writes nothing.
    function automatic int m_dest(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        if (op == 0) return (w[5:0] == 6'h08) ? 0 : int'(w[15:11]);
        if (op == 3) return 31;
        if ((op >= 8 && op <= 15) || op == 32 || op == 35 || op == 36) return int'(w[20:16]);
        return 0;
    endfunction

    function automatic bit m_is_load(input logic [31:0] w);
        return (w[31:26] == 6'h23) || (w[31:26] == 6'h20) || (w[31:26] == 6'h24);
    endfunction

    function automatic bit m_reads_rs(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        if (op == 0) return !(w[5:0] == 6'h00 || w[5:0] == 6'h02 || w[5:0] == 6'h03);
        return (op >= 4 && op <= 14) || op == 32 || op == 35 || op == 36 || op == 40 || op == 43;
    endfunction

    function automatic bit m_reads_rt(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        return op == 0 || op == 4 || op == 5 || op == 40 || op == 43;
    endfunction

    function automatic logic [1:0] m_sel(input bit used, input int r);
        if (!used || r == 0) return 2'b00;
        if (m_dest(m_ex) == r) return 2'b10;
        if (m_dest(m_mem) == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_calc_stall(input logic [31:0] w, input bit flush);
        int d;
        d = m_dest(m_ex);
        if (flush || !m_is_load(m_ex) || d == 0) return 1'b0;
        return (m_reads_rs(w) && int'(w[25:21]) == d) || (m_reads_rt(w) && int'(w[20:16]) == d);
    endfunction

    task automatic model_reset();
        m_ex = 32'd0;
        m_mem = 32'd0;
        m_fa = 2'b00;
        m_fb = 2'b00;
        m_stall = 1'b0;
    endtask

    // One pipeline cycle: drive at negedge, check settled outputs, advance model at posedge.
    task automatic cycle(input logic [31:0] ins, input bit hold, input bit flush);
        logic [1:0] nfa;
        logic [1:0] nfb;
        @(negedge CLOCK);
        Instruction_IN = ins;
        Hold_IN = hold;
        Flush_IN = flush;
        #1;
        m_stall = m_calc_stall(ins, flush);
        check_eq("stall", {1'b0, Stall_OUT}, {1'b0, m_stall});
        check_eq("fwdA", ForwardA_OUT, m_fa);
        check_eq("fwdB", ForwardB_OUT, m_fb);
        nfa = m_sel(m_reads_rs(ins), int'(ins[25:21]));
        nfb = m_sel(m_reads_rt(ins), int'(ins[20:16]));
        @(posedge CLOCK);
        if (!hold) begin
            m_mem = m_ex;
            if (m_stall || flush) begin
                m_ex = 32'd0;
                m_fa = 2'b00;
                m_fb = 2'b00;
            end else begin
                m_ex = ins;
                m_fa = nfa;
                m_fb = nfb;
            end
        end
        #1;
    endtask

    function automatic int rand_reg();
        int k;
        k = int'($urandom_range(0, 5));
        return (k == 5) ? 31 : k;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [31:0] w;
        k = int'($urandom_range(0, 13));
        case (k)
            0:  w = 32'd0;
            1:  w = r_type(rand_reg(), rand_reg(), rand_reg(), 32 + int'($urandom_range(0, 7)));
            2:  w = r_type(rand_reg(), rand_reg(), rand_reg(), int'($urandom_range(0, 3)));
            3:  w = r_type(rand_reg(), rand_reg(), rand_reg(), 8);
            4:  w = r_type(rand_reg(), rand_reg(), rand_reg(), 9);
            5:  w = i_type(int'($urandom_range(8, 14)), rand_reg(), rand_reg(), 7);
            6:  w = i_type(15, rand_reg(), rand_reg(), 1);
            7:  w = i_type(35, rand_reg(), rand_reg(), 4);
            8:  w = i_type($urandom_range(0, 1) == 1 ? 32 : 36, rand_reg(), rand_reg(), 0);
            9:  w = i_type($urandom_range(0, 1) == 1 ? 43 : 40, rand_reg(), rand_reg(), 8);
            10: w = i_type(int'($urandom_range(4, 7)), rand_reg(), rand_reg(), 2);
            11: w = {($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03, 26'h123};
            12: w = i_type(int'($urandom_range(16, 63)), rand_reg(), rand_reg(), 3);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        bit          adv;
        bit          h;
        bit          f;

        // Reset state
        #2;
        check_eq("rst_stall", {1'b0, Stall_OUT}, 2'b00);
        check_eq("rst_fwdA", ForwardA_OUT, 2'b00);
        check_eq("rst_fwdB", ForwardB_OUT, 2'b00);
        @(negedge CLOCK);
        RESET = 1'b0;
        model_reset();
        repeat (3) cycle(32'd0, 0, 0);

        // EX->EX forward: add $3,$1,$2 ; sub $4,$3,$5
        cycle(r_type(1, 2, 3, 32), 0, 0);
        cycle(r_type(3, 5, 4, 34), 0, 0);
        check_eq("alu_fwdA", ForwardA_OUT, 2'b10);
        check_eq("alu_fwdB", ForwardB_OUT, 2'b00);

        // MEM forward: add $3 ; nop ; or $6,$5,$3
        cycle(r_type(1, 2, 3, 32), 0, 0);
        cycle(32'd0, 0, 0);
        cycle(r_type(5, 3, 6, 37), 0, 0);
        check_eq("mem_fwdB", ForwardB_OUT, 2'b01);
        check_eq("mem_fwdA", ForwardA_OUT, 2'b00);

        // Load-use: lw $2,0($1) ; add $4,$2,$2 costs one stall
        cycle(i_type(35, 1, 2, 0), 0, 0);
        cycle(r_type(2, 2, 4, 32), 0, 0);
        check_eq("lu_stalled", {1'b0, m_stall}, 2'b01);
        cycle(r_type(2, 2, 4, 32), 0, 0);
        check_eq("lu_fwdA", ForwardA_OUT, 2'b01);
        check_eq("lu_fwdB", ForwardB_OUT, 2'b01);

        // Write to $0 is no write
        cycle(i_type(8, 0, 0, 5), 0, 0);
        cycle(r_type(0, 0, 7, 32), 0, 0);
        check_eq("zero_fwdA", ForwardA_OUT, 2'b00);
        check_eq("zero_fwdB", ForwardB_OUT, 2'b00);

        // jal ; jr $31
        cycle({6'h03, 26'h40}, 0, 0);
        cycle(r_type(31, 0, 0, 8), 0, 0);
        check_eq("jr_fwdA", ForwardA_OUT, 2'b10);

        // Flush with a load-use condition: no stall, bubble enters EX
        cycle(i_type(35, 1, 2, 0), 0, 0);
        cycle(i_type(4, 2, 3, 4), 0, 1);
        check_eq("flush_stall", {1'b0, m_stall}, 2'b00);
        cycle(32'd0, 0, 0);
        check_eq("flush_fwdA", ForwardA_OUT, 2'b00);

        // Hold mid-dependency keeps selects
        cycle(r_type(1, 2, 3, 32), 0, 0);
        cycle(r_type(3, 3, 4, 34), 0, 0);
        repeat (3) cycle(r_type(4, 1, 5, 32), 1, 1);
        check_eq("hold_fwdA", ForwardA_OUT, 2'b10);
        check_eq("hold_fwdB", ForwardB_OUT, 2'b10);
        cycle(r_type(4, 1, 5, 32), 0, 0);

        // Asynchronous reset in the middle of a stall, with Hold asserted
        cycle(i_type(35, 1, 2, 0), 0, 0);
        @(negedge CLOCK);
        Instruction_IN = r_type(2, 2, 4, 32);
        Hold_IN = 1'b1;
        #1;
        check_eq("pre_rst_stall", {1'b0, Stall_OUT}, 2'b01);
        RESET = 1'b1;
        #1;
        model_reset();
        check_eq("mid_rst_stall", {1'b0, Stall_OUT}, 2'b00);
        check_eq("mid_rst_fwdA", ForwardA_OUT, 2'b00);
        check_eq("mid_rst_fwdB", ForwardB_OUT, 2'b00);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        Hold_IN = 1'b0;
        cycle(r_type(2, 2, 4, 32), 0, 0);

        // Randomized traffic; ID instruction is re-presented while held or stalled
        cur = 32'd0;
        adv = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (adv) cur = rand_instr();
            h = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 9) == 0);
            cycle(cur, h, f);
            adv = !h && !m_stall;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Tracks the destination registers of in-flight instructions in the five-stage MIPS pipeline and produces EX-stage operand forwarding selects and the load-use stall. It sits beside the ID stage, consuming the raw 32-bit instruction word latched in IF/ID. It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB destination bookkeeping. Its outputs drive the EX operand muxes and the IF/ID and PC hold enables.

## Interface
- No parameters; register file is fixed at 32 × 32-bit with $0 hard-wired to zero.
- CLOCK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-high; clears all tracking state.
- Instruction_IN  in  32  instruction currently in ID; all-zero word is a NOP.
- Hold_IN  in  1  global freeze (e.g. memory wait); no tracking state advances.
- Flush_IN  in  1  taken branch/jump resolved in ID; the ID instruction must not enter EX.
- Stall_OUT  out  1  load-use hazard; holds PC and IF/ID, bubbles EX. Combinational.
- ForwardA_OUT  out  2  EX rs-operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result. Registered.
- ForwardB_OUT  out  2  EX rt-operand select, same encoding. Registered.

## Operation
- ID decode, from opcode/funct:
  - Dest = rd for R-type except jr (funct 08), which has no dest; jalr (09) writes rd.
  - Dest = rt for addi/addiu/slti/sltiu/andi/ori/xori/lui (08–0F) and lw/lb/lbu (23/20/24).
  - Dest = 31 for jal (03).
  - No dest for j (02), beq/bne/blez/bgtz (04–07), sw/sb (2B/28).
  - Any dest of 0 is treated as no dest.
- Source use, from the same fields:
  - Uses rs: all R-type except shifts sll/srl/sra (funct 00/02/03); all I-type except lui; all loads, stores and branches.
  - Uses rt: R-type, beq/bne, sw/sb.
- Tracking slots, each holding {dest, writes, is_load}:
  - Slot E (ID/EX), slot M (EX/MEM), slot W (MEM/WB).
  - Each rising edge with Hold_IN=0: W←M, M←E, E←ID entry.
  - The ID entry is replaced by a bubble (writes=0) when Stall_OUT=1 or Flush_IN=1.
- Forward select, computed at ID and registered into EX with slot E:
  - Per source register: if used and slot E writes with dest match → 10.
  - Else if slot M writes with dest match → 01.
  - Else 00.
  - Slot E has priority (youngest wins).
  - A bubble loads 00/00.
  - The regfile is write-first, so a match against slot W needs no select.
- Stall_OUT = slot E is_load & writes & (uses_rs & rs==E.dest | uses_rt & rt==E.dest), gated by !Flush_IN.
  - A stalled instruction re-evaluates next cycle against the advanced slots. Its load producer is then in M, giving select 01.

## Timing
- Reset values: all slots writes=0 and is_load=0; ForwardA_OUT=ForwardB_OUT=00; Stall_OUT=0.
- Forward selects have 1-cycle latency: they are valid during the cycle the instruction occupies EX.
- Load-use costs exactly one stall cycle; ALU-to-ALU dependence costs zero.
- Hold_IN=1: all slots and selects keep their values; Stall_OUT still reflects current state. Hold overrides Flush and Stall.
- Flush_IN=1 and Stall_OUT condition together: the bubble enters E and Stall_OUT=0.
- Same register as rs and rt: both selects are set identically.
- RESET mid-stream: state clears immediately, regardless of CLOCK or Hold_IN.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW, …
  - funct constants: FN_JR, FN_JALR, FN_SLL, …
  - the forward select constants FWD_REG=00, FWD_MEM=10, FWD_WB=01
  - the slot record typedef.
- One sub-module, hfu_decode (combinational): produces rs, rt, dest, writes, is_load, uses_rs, uses_rt from the instruction word.

## Test plan
- Reset → Stall_OUT=0, ForwardA/B=00; 3 NOPs keep all slots empty.
- add $3,$1,$2 then sub $4,$3,$5 → sub in EX with ForwardA=10, ForwardB=00; no stall.
- add $3,… ; nop ; or $6,$5,$3 → or in EX with ForwardB=01.
- lw $2,0($1) ; add $4,$2,$2 → Stall_OUT=1 one cycle; add enters EX with ForwardA=ForwardB=01.
- Write-to-zero check: addi $0,$0,5 ; add $7,$0,$0 → selects 00.
  - jal then jr $31 → ForwardA=10.
- Boundary cases:
  - lw $2 ; beq $2 with Flush_IN=1 in the same cycle → Stall_OUT=0, bubble enters E.
  - Hold_IN=1 for 3 cycles mid-dependency → selects unchanged.
  - RESET pulse mid-stall → all outputs 00/0.
